// File: rtl/inv_cipher_iter_pkg.sv
// Shared AES types, S-box tables, round constants and GF(2^8) helpers.
// Imported by the inverse cipher top, its round datapath and its bus interface.
package inv_cipher_iter_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [0:3] word_t;
    typedef word_t [0:3] state_t;

    typedef enum logic [1:0] {
        MODE_FIRST,
        MODE_MIDDLE,
        MODE_LAST
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        KEYEXP,
        ROUND,
        DONE
    } fsm_t;

    localparam byte_t SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam byte_t RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p = '0;
        byte_t x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic word_t rotWord(input word_t w);
        return {w[1], w[2], w[3], w[0]};
    endfunction

    function automatic word_t subWord(input word_t w);
        word_t r;
        for (int i = 0; i < 4; i++) r[i] = SBOX[w[i]];
        return r;
    endfunction

endpackage

// File: rtl/inv_cipher_iter_if.sv
// Block handshake bundle: ciphertext/key in with i_valid/i_ready,
// plaintext out with o_valid/o_ready. slave = cipher side, master = client.
interface inv_cipher_iter_if;
    import inv_cipher_iter_pkg::*;

    logic   i_valid;
    logic   i_ready;
    state_t data;
    state_t key;
    logic   o_valid;
    logic   o_ready;
    state_t o;

    modport slave (
        input  i_valid, data, key, o_ready,
        output i_ready, o_valid, o
    );

    modport master (
        output i_valid, data, key, o_ready,
        input  i_ready, o_valid, o
    );

endinterface

// File: rtl/inv_cipher_iter_inv_round.sv
// Combinational AES inverse round: first (AddRoundKey only), middle and last.
// Ports: st/rk in, mode in, stNext out.
module inv_round
    import inv_cipher_iter_pkg::*;
(
    input  state_t st,
    input  state_t rk,
    input  mode_t  mode,
    output state_t stNext
);

    state_t shifted;
    state_t subbed;
    state_t added;
    state_t mixed;

    always_comb begin
        shifted = '0;
        subbed  = '0;
        mixed   = '0;
        // Row r rotates right by r: column c takes column c-r.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shifted[c][r] = st[(c + 4 - r) % 4][r];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                subbed[c][r] = INV_SBOX[shifted[c][r]];
        added = subbed ^ rk;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mixed[c][r] = gmul(added[c][r], 8'd14)
                            ^ gmul(added[c][(r + 1) % 4], 8'd11)
                            ^ gmul(added[c][(r + 2) % 4], 8'd13)
                            ^ gmul(added[c][(r + 3) % 4], 8'd9);
        stNext = st ^ rk;
        unique case (mode)
            MODE_FIRST:  stNext = st ^ rk;
            MODE_MIDDLE: stNext = mixed;
            MODE_LAST:   stNext = added;
            default:     stNext = st ^ rk;
        endcase
    end

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 decryptor: forward key expansion to K10, then 11 rounds
// backwards. Ports: clk, rst (async, active-high), bus (slave handshake).
module inv_cipher_iter
    import inv_cipher_iter_pkg::*;
(
    input logic           clk,
    input logic           rst,
    inv_cipher_iter_if.slave bus
);

    fsm_t       state;
    fsm_t       stateNext;
    state_t     st;
    state_t     stNext;
    state_t     rk;
    state_t     rkNext;
    state_t     roundOut;
    state_t     fwdKey;
    state_t     invKey;
    logic [3:0] rc;
    logic [3:0] rcNext;
    logic [3:0] rconIdx;
    byte_t      rcon;
    word_t      rconWord;
    word_t      subIn;
    word_t      subOut;
    mode_t      mode;

    inv_round uRound (
        .st     (st),
        .rk     (rk),
        .mode   (mode),
        .stNext (roundOut)
    );

    always_comb begin
        mode = MODE_MIDDLE;
        if (rc == 4'd10)     mode = MODE_FIRST;
        else if (rc == 4'd0) mode = MODE_LAST;
    end

    // One SubWord serves both directions; going backwards it needs the
    // previous key's w3, which is recovered as w3 ^ w2.
    assign subIn    = (state == ROUND) ? rotWord(rk[3] ^ rk[2])
                                       : rotWord(rk[3]);
    assign subOut   = subWord(subIn);
    assign rconIdx  = (state == ROUND) ? rc - 4'd1 : rc;
    assign rcon     = (rconIdx < 4'd10) ? RCON[rconIdx] : 8'h00;
    assign rconWord = {rcon, 8'h00, 8'h00, 8'h00};

    always_comb begin
        fwdKey[0] = rk[0] ^ subOut ^ rconWord;
        fwdKey[1] = rk[1] ^ fwdKey[0];
        fwdKey[2] = rk[2] ^ fwdKey[1];
        fwdKey[3] = rk[3] ^ fwdKey[2];
        invKey[3] = rk[3] ^ rk[2];
        invKey[2] = rk[2] ^ rk[1];
        invKey[1] = rk[1] ^ rk[0];
        invKey[0] = rk[0] ^ subOut ^ rconWord;
    end

    always_comb begin
        stateNext = state;
        stNext    = st;
        rkNext    = rk;
        rcNext    = rc;
        unique case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    stNext    = bus.data;
                    rkNext    = bus.key;
                    rcNext    = 4'd0;
                    stateNext = KEYEXP;
                end
            end
            KEYEXP: begin
                rkNext = fwdKey;
                rcNext = rc + 4'd1;
                if (rc == 4'd9) stateNext = ROUND;
            end
            ROUND: begin
                stNext = roundOut;
                if (rc == 4'd0) begin
                    stateNext = DONE;
                end else begin
                    rkNext = invKey;
                    rcNext = rc - 4'd1;
                end
            end
            DONE: begin
                if (bus.o_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            rk    <= '0;
            rc    <= '0;
        end else begin
            state <= stateNext;
            st    <= stNext;
            rk    <= rkNext;
            rc    <= rcNext;
        end
    end

    assign bus.i_ready = (state == IDLE);
    assign bus.o_valid = (state == DONE);
    assign bus.o       = st;

endmodule
